pll_lock_ctrl: RTL and testbench
================================

# pll_lock_ctrl

Reset and lock sequencer for the system PLL (50 MHz `refclk` in, 10 MHz `outclk_0` out). It drives the PLL reset, synchronizes and qualifies the PLL `locked` flag, and releases the downstream system reset only after lock has been stable. It retries on lock timeout, recovers from loss of lock, and reports status to the rest of the design. The block runs entirely on the free-running `refclk` and sits between the board reset and the PLL wrapper.

## Interface
Parameters:
- `RST_CYCLES`, 16: width of the PLL reset pulse, in refclk cycles.
- `LOCK_TIMEOUT`, 50000: refclk cycles allowed in WAIT_LOCK before a retry.
- `STABLE_CYCLES`, 1024: refclk cycles `locked` must stay high before release.
- `MAX_RETRIES`, 3: number of timeout retries before FAIL (range 0..15).
- `CNT_W`, 16: shared counter width. Every cycle parameter must be ≤ 2^CNT_W−1.

Ports:
- `refclk`  in  1: free-running reference clock; the only clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `pll_locked`  in  1: PLL `locked` flag; asynchronous to `refclk`.
- `restart`  in  1: single-cycle request to restart the full sequence.
- `pll_rst`  out  1: drives the PLL `rst`; active high.
- `sys_rst_n`  out  1: active-low reset for logic clocked by `outclk_0`.
- `ready`  out  1: PLL is locked and stable; the system is running.
- `fail`  out  1: retries are exhausted; the block is halted.
- `retry_cnt`  out  4: timeout retries used in the current attempt.
- `lock_loss_cnt`  out  8: loss-of-lock events seen in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `lk`. The FSM uses only `lk`.
- One counter `cnt` is shared by all timed states. It clears on every state entry. Each timed state exits when `cnt == PARAM−1`.
- States and transitions:
  - **RESET_PLL**: `pll_rst=1`. Holds for `RST_CYCLES` cycles, then goes to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_rst=0`.
    - `lk=1` → STABILIZE.
    - Timeout with `retry_cnt<MAX_RETRIES` → increment `retry_cnt`, go to RESET_PLL.
    - Timeout with `retry_cnt==MAX_RETRIES` → FAIL.
  - **STABILIZE**:
    - `lk=0` → WAIT_LOCK. The timeout restarts; `retry_cnt` is unchanged.
    - `lk` held for `STABLE_CYCLES` cycles → RUN.
  - **RUN**: `sys_rst_n=1`, `ready=1`.
    - `lk=0` → increment `lock_loss_cnt` (saturating), clear `retry_cnt`, then apply the loss action (see Configuration).
  - **FAIL**: `pll_rst=1`, `fail=1`. Exits only on `restart` or `rst_n`.
- `restart=1` in any state, including RUN and FAIL: go to RESET_PLL, clear `retry_cnt`, keep `lock_loss_cnt`. It has priority over every other transition in the same cycle.
- `sys_rst_n` and `ready` are 1 only in RUN. Both drop on the same edge that leaves RUN.
- `rst_n` mid-sequence: on the next edge, enter RESET_PLL with all counters cleared. The sequence restarts from the beginning.

## Timing
- All outputs are registered and change on the `refclk` edge that enters the new state.
- Reset values: `pll_rst=1`, `sys_rst_n=0`, `ready=0`, `fail=0`, `retry_cnt=0`, `lock_loss_cnt=0`. The state is RESET_PLL with `cnt=0`.
- PLL reset pulse: `pll_rst` is high for exactly `RST_CYCLES` edges after the first edge where `rst_n=1` is sampled.
- Lock qualification: let E be the first edge that samples `pll_locked=1`.
  - `lk=1` after edge E+1.
  - STABILIZE is entered at E+2.
  - `ready` and `sys_rst_n` rise at E+2+`STABLE_CYCLES`.
- Loss of lock: let F be the first edge that samples `pll_locked=0` while in RUN. `ready` and `sys_rst_n` fall at F+2.
- `restart` sampled high at edge R: `pll_rst=1`, `ready=0`, `fail=0` after R.
- Any `pll_locked` pulse shorter than 2 cycles may be missed. This is acceptable.

## Configuration
- Macro: `PLL_CTRL_AUTO_RECOVER_EN`.
- Defined: loss of lock in RUN goes to RESET_PLL, which automatically re-sequences the PLL.
- Undefined: loss of lock in RUN goes to FAIL (`fail=1`, `pll_rst=1`). `lock_loss_cnt` still increments. Recovery requires `restart`.

## Test plan
Parameters for all scenarios: `RST_CYCLES=4`, `LOCK_TIMEOUT=20`, `STABLE_CYCLES=8`, `MAX_RETRIES=2`.

1. Release `rst_n`; raise `pll_locked` 5 cycles after `pll_rst` falls and hold it. Expected: `pll_rst` high for exactly 4 cycles; `ready` and `sys_rst_n` rise at E+10; `retry_cnt=0`.
2. Keep `pll_locked=0` permanently. Expected: 3 `pll_rst` pulses of 4 cycles, each separated by a 20-cycle WAIT_LOCK; `retry_cnt` steps 0→1→2; then `fail=1` and `pll_rst=1` held.
3. Drop `pll_locked` for 3 cycles when STABILIZE has `cnt=5`. Expected: return to WAIT_LOCK; `ready` stays 0; `retry_cnt` unchanged; `ready` rises 10 edges after `pll_locked` returns.
4. In RUN, with the macro defined, drop `pll_locked`. Expected: `ready` falls at F+2; `lock_loss_cnt=1`; a 4-cycle `pll_rst` pulse; `ready` returns after re-lock. With the macro undefined: `fail=1` and no re-sequencing.
5. From FAIL (after scenario 2), pulse `restart` for one cycle. Expected: `fail=0`, `retry_cnt=0`, a 4-cycle `pll_rst` pulse; `lock_loss_cnt` preserved.
6. Force 260 loss/re-lock cycles. Expected: `lock_loss_cnt` saturates at 255 and does not wrap.

Source files
------------

// File: rtl/pll_lock_ctrl.sv
// Reset and lock sequencer for the system PLL: pulses the PLL reset, qualifies lock, releases sys_rst_n.
// Optional macro PLL_CTRL_AUTO_RECOVER_EN: loss of lock in RUN re-sequences the PLL instead of halting in FAIL.
module pll_lock_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lk_meta;
    logic             lk;

    // Two-flop synchronizer for the asynchronous locked flag.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk      <= lk_meta;
        end
    end

    // Sequencer; outputs are assigned on the edge that enters each state.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state         <= S_RESET_PLL;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= 4'd0;
            lock_loss_cnt <= 8'd0;
        end else if (restart) begin
            state     <= S_RESET_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= 4'd0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            case (state)
                S_RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state   <= S_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk) begin
                        state <= S_STABILIZE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt < RETRY_MAX) begin
                            state     <= S_RESET_PLL;
                            retry_cnt <= retry_cnt + 4'd1;
                        end else begin
                            state <= S_FAIL;
                            fail  <= 1'b1;
                        end
                    end
                end
                S_STABILIZE: begin
                    // A dropout sends us back to waiting with a fresh timeout.
                    if (!lk) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        sys_rst_n <= 1'b1;
                        ready     <= 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= '0;
                    if (!lk) begin
                        if (lock_loss_cnt != 8'hFF) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
                        retry_cnt <= 4'd0;
                        sys_rst_n <= 1'b0;
                        ready     <= 1'b0;
                        pll_rst   <= 1'b1;
`ifdef PLL_CTRL_AUTO_RECOVER_EN
                        state     <= S_RESET_PLL;
`else
                        state     <= S_FAIL;
                        fail      <= 1'b1;
`endif
                    end
                end
                S_FAIL: begin
                    cnt <= '0;
                end
                default: begin
                    state     <= S_RESET_PLL;
                    cnt       <= '0;
                    pll_rst   <= 1'b1;
                    sys_rst_n <= 1'b0;
                    ready     <= 1'b0;
                    fail      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scenario bench for pll_lock_ctrl: expectations are queued as stimulus is applied, then matched to observations.
module tb_pll_lock_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    localparam int SIG_PLL_RST = 0;
    localparam int SIG_READY   = 1;
    localparam int SIG_FAIL    = 2;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    typedef struct {
        string name;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   obs_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    pll_lock_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (16)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .restart      (restart),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    function automatic void expect_v(input string name, input int val);
        sb.push_back('{name: name, val: val});
    endfunction

    function automatic void observe(input int val);
        obs_q.push_back(val);
    endfunction

    function automatic logic sig(input int id);
        case (id)
            SIG_PLL_RST: return pll_rst;
            SIG_READY:   return ready;
            default:     return fail;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // Edge number at which the signal is first seen at val, or -1 when the budget expires.
    task automatic wait_sig(input int id, input logic val, input int budget, output int edge_no);
        edge_no = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge refclk);
            if (sig(id) === val) begin
                edge_no = cyc;
                return;
            end
        end
    endtask

    // Number of consecutive samples (including the current one) at val, capped at budget.
    task automatic run_len(input int id, input logic val, input int budget, output int n);
        n = 1;
        while (n < budget) begin
            @(negedge refclk);
            if (sig(id) !== val) return;
            n++;
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge refclk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        int   o, fe, rel;
        rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
        tick(3);
        expect_v("reset_outputs", 32'h8000);
        observe(int'({pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt}));
        rst_n = 1'b1;
        rel = cyc + 1;
        expect_v("pll_rst_fall_edge_after_release", RST_CYCLES);
        wait_sig(SIG_PLL_RST, 1'b0, 50, fe);
        observe((fe < 0) ? -1 : fe - rel + 1);
        while (obs_q.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %0d, required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_lock();
        exp_t e;
        int   o, e_edge, re;
        tick(4);
        pll_locked = 1'b1;
        e_edge = cyc + 1;
        expect_v("lock_to_ready_edges", 2 + STABLE_CYCLES);
        wait_sig(SIG_READY, 1'b1, 100, re);
        observe((re < 0) ? -1 : re - e_edge);
        expect_v("run_sys_rst_pll_rst_fail_retry", 64);
        observe(int'({sys_rst_n, pll_rst, fail, retry_cnt}));
        while (obs_q.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %0d, required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_lock_loss();
        exp_t e;
        int   o, f, x, n;
        tick(3);
        pll_locked = 1'b0;
        f = cyc + 1;
        expect_v("loss_to_ready_fall_edges", 2);
        wait_sig(SIG_READY, 1'b0, 20, x);
        observe((x < 0) ? -1 : x - f);
        expect_v("loss_sys_rst_pll_rst_llc", 257);
        observe(int'({sys_rst_n, pll_rst, lock_loss_cnt}));
`ifdef PLL_CTRL_AUTO_RECOVER_EN
        expect_v("recover_pll_rst_width", RST_CYCLES);
        run_len(SIG_PLL_RST, 1'b1, 50, n);
        observe(n);
        pll_locked = 1'b1;
        f = cyc + 1;
        expect_v("relock_to_ready_edges", 2 + STABLE_CYCLES);
        wait_sig(SIG_READY, 1'b1, 100, x);
        observe((x < 0) ? -1 : x - f);
`else
        expect_v("loss_fail_ready", 2);
        observe(int'({fail, ready}));
        expect_v("fail_pll_rst_hold", 40);
        run_len(SIG_PLL_RST, 1'b1, 40, n);
        observe(n);
        expect_v("fail_still_halted", 2);
        observe(int'({fail, ready}));
`endif
        while (obs_q.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %0d, required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_timeout_fail();
        exp_t e;
        int   o, n;
        pll_locked = 1'b0;
        pulse_restart();
        expect_v("restart_pll_rst_ready_fail_retry", 64);
        observe(int'({pll_rst, ready, fail, retry_cnt}));
        expect_v("pulse0_width", RST_CYCLES);
        run_len(SIG_PLL_RST, 1'b1, 50, n);
        observe(n);
        for (int k = 1; k <= MAX_RETRIES; k++) begin
            expect_v($sformatf("wait%0d_len", k - 1), LOCK_TIMEOUT);
            run_len(SIG_PLL_RST, 1'b0, 60, n);
            observe(n);
            expect_v($sformatf("retry_cnt_step%0d", k), k);
            observe(int'(retry_cnt));
            expect_v($sformatf("pulse%0d_width", k), RST_CYCLES);
            run_len(SIG_PLL_RST, 1'b1, 50, n);
            observe(n);
        end
        expect_v("final_wait_len", LOCK_TIMEOUT);
        run_len(SIG_PLL_RST, 1'b0, 60, n);
        observe(n);
        expect_v("fail_state_fail_pllrst_retry", 32 + 16 + MAX_RETRIES);
        observe(int'({fail, pll_rst, retry_cnt}));
        expect_v("fail_pll_rst_held", 40);
        run_len(SIG_PLL_RST, 1'b1, 40, n);
        observe(n);
        expect_v("fail_llc_kept", 1);
        observe(int'(lock_loss_cnt));
        while (obs_q.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %0d, required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_restart();
        exp_t e;
        int   o, n, e_edge, x;
        pulse_restart();
        expect_v("restart_fail_retry_pllrst_llc", 257);
        observe(int'({fail, retry_cnt, pll_rst, lock_loss_cnt}));
        expect_v("restart_pulse_width", RST_CYCLES);
        run_len(SIG_PLL_RST, 1'b1, 50, n);
        observe(n);
        pll_locked = 1'b1;
        e_edge = cyc + 1;
        expect_v("restart_lock_to_ready", 2 + STABLE_CYCLES);
        wait_sig(SIG_READY, 1'b1, 100, x);
        observe((x < 0) ? -1 : x - e_edge);
        // Loss of lock and restart land on the same edge: restart wins, no loss counted.
        pll_locked = 1'b0;
        tick(2);
        pulse_restart();
        expect_v("restart_priority_fail_pllrst_ready_llc", 513);
        observe(int'({fail, pll_rst, ready, lock_loss_cnt}));
        while (obs_q.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %0d, required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_stabilize_glitch();
        exp_t e;
        int   o, x, e_edge, h;
        pll_locked = 1'b0;
        rst_n = 1'b0;
        @(negedge refclk);
        expect_v("rst_mid_clears_all", 32'h8000);
        observe(int'({pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt}));
        rst_n = 1'b1;
        wait_sig(SIG_PLL_RST, 1'b0, 50, x);
        wait_sig(SIG_PLL_RST, 1'b1, 50, x);
        wait_sig(SIG_PLL_RST, 1'b0, 50, x);
        expect_v("glitch_retry_before", 1);
        observe(int'(retry_cnt));
        pll_locked = 1'b1;
        e_edge = cyc + 1;
        tick(6);
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        h = cyc + 1;
        expect_v("glitch_return_to_ready", 2 + STABLE_CYCLES);
        wait_sig(SIG_READY, 1'b1, 100, x);
        observe((x < 0) ? -1 : x - h);
        expect_v("glitch_retry_unchanged", 1);
        observe(int'(retry_cnt));
        while (obs_q.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %0d, required %0d e=%0d", e.name, o, e.val, e_edge);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        int   o, x, timeouts;
        timeouts = 0;
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            wait_sig(SIG_READY, 1'b0, 20, x);
            if (x < 0) timeouts++;
`ifndef PLL_CTRL_AUTO_RECOVER_EN
            pulse_restart();
`endif
            pll_locked = 1'b1;
            expect_v($sformatf("llc_iter%0d", i), (i + 1 > 255) ? 255 : i + 1);
            wait_sig(SIG_READY, 1'b1, 100, x);
            if (x < 0) timeouts++;
            observe(int'(lock_loss_cnt));
        end
        expect_v("saturation_wait_timeouts", 0);
        observe(timeouts);
        while (obs_q.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %0d, required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_rst_mid();
        exp_t e;
        int   o, rel, fe;
        tick(2);
        rst_n = 1'b0;
        @(negedge refclk);
        expect_v("rst_from_saturated_run", 32'h8000);
        observe(int'({pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt}));
        rst_n = 1'b1;
        rel = cyc + 1;
        expect_v("rst_mid_pll_rst_fall_edge", RST_CYCLES);
        wait_sig(SIG_PLL_RST, 1'b0, 50, fe);
        observe((fe < 0) ? -1 : fe - rel + 1);
        while (obs_q.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %0d, required %0d", e.name, o, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_lock_loss();
        test_timeout_fail();
        test_restart();
        test_stabilize_glitch();
        test_saturation();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
